// File: rtl/decode_stage_pkg.sv
//------------------------------------------------------------------------------
// Module  : instruction (package)
// Brief   : Instruction field map, opcode constants, decoded record and
//           decode-stage state encoding.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package instruction;

    localparam int c_instr_w     = 32;
    localparam int c_kind_lsb    = 29;
    localparam int c_cond_lsb    = 26;
    localparam int c_op_lsb      = 21;
    localparam int c_rd_lsb      = 16;
    localparam int c_rs_lsb      = 11;
    localparam int c_rq_lsb      = 6;
    localparam int c_shtype_lsb  = 4;
    localparam int c_imm_w       = 11;
    localparam int c_model_imm_w = 26;
    localparam int c_alu_cfg_w   = 7;

    localparam logic [2:0] KIND_RRR     = 3'd0;
    localparam logic [2:0] KIND_RRI     = 3'd1;
    localparam logic [2:0] KIND_MEMORY  = 3'd2;
    localparam logic [2:0] KIND_MODEL   = 3'd3;
    localparam logic [2:0] KIND_CUSTOM  = 3'd4;
    localparam logic [2:0] KIND_INVALID = 3'd7;

    localparam logic [2:0] COND_AL = 3'd0;
    localparam logic [2:0] COND_NV = 3'd7;

    localparam logic [4:0] BINOP_ADD = 5'd0;
    localparam logic [4:0] BINOP_SUB = 5'd1;
    localparam logic [4:0] BINOP_AND = 5'd2;
    localparam logic [4:0] BINOP_OR  = 5'd3;
    localparam logic [4:0] BINOP_XOR = 5'd4;
    localparam logic [4:0] BINOP_MUL = 5'd5;
    localparam logic [4:0] BINOP_CMP = 5'd6;

    // Bit 0 of a memory op selects the register (0) or immediate (1) form.
    localparam logic [4:0] MEMOP_LDRW_RR = 5'd0;
    localparam logic [4:0] MEMOP_LDRW_RI = 5'd1;
    localparam logic [4:0] MEMOP_STRW_RR = 5'd2;
    localparam logic [4:0] MEMOP_STRW_RI = 5'd3;

    typedef struct packed {
        logic [2:0]             kind;
        logic [2:0]             cond;
        logic [4:0]             op;
        logic [4:0]             rd;
        logic [4:0]             rs;
        logic [4:0]             rq;
        logic [1:0]             shift_type;
        logic [4:0]             shift_amt;
        logic [31:0]            immedate;
        logic [c_alu_cfg_w-1:0] alu_config;
    } s_decoded;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } e_stage_state;

    // One-hot ALU selection per binop.
    function automatic logic [c_alu_cfg_w-1:0] binop_cfg(input logic [4:0] op);
        return c_alu_cfg_w'(1) << op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_comb.sv
//------------------------------------------------------------------------------
// Module  : decode_comb
// Brief   : Pure combinational instruction word -> decoded record + illegal.
//           KIND_CUSTOM is legal only when DECODE_STAGE_CUSTOM_EN is defined.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module decode_comb
    import instruction::*;
(
    input  logic [c_instr_w-1:0] i_instr,
    output s_decoded             o_decoded,
    output logic                 o_illegal
);

    logic [2:0]  w_kind;
    logic [2:0]  w_cond;
    logic [4:0]  w_op;
    logic [31:0] w_simm;
    logic [31:0] w_zimm;
    s_decoded    w_dec;
    logic        w_ill;

    assign w_kind = i_instr[c_kind_lsb +: 3];
    assign w_cond = i_instr[c_cond_lsb +: 3];
    assign w_op   = i_instr[c_op_lsb +: 5];
    assign w_simm = {{(32-c_imm_w){i_instr[c_imm_w-1]}}, i_instr[c_imm_w-1:0]};
    assign w_zimm = {{(32-c_model_imm_w){1'b0}}, i_instr[c_model_imm_w-1:0]};

    always_comb begin
        w_dec      = '0;
        w_ill      = 1'b0;
        w_dec.kind = w_kind;
        w_dec.cond = w_cond;
        w_dec.op   = w_op;
        case (w_kind)
            KIND_RRR: begin
                w_ill            = (w_op > BINOP_CMP);
                w_dec.rd         = i_instr[c_rd_lsb +: 5];
                w_dec.rs         = i_instr[c_rs_lsb +: 5];
                w_dec.rq         = i_instr[c_rq_lsb +: 5];
                w_dec.shift_type = i_instr[c_shtype_lsb +: 2];
                w_dec.shift_amt  = {1'b0, i_instr[3:0]};
                w_dec.alu_config = binop_cfg(w_op);
            end
            KIND_RRI: begin
                w_ill            = (w_op > BINOP_CMP);
                w_dec.rd         = i_instr[c_rd_lsb +: 5];
                w_dec.rs         = i_instr[c_rs_lsb +: 5];
                w_dec.immedate   = w_simm;
                w_dec.alu_config = binop_cfg(w_op);
            end
            KIND_MEMORY: begin
                w_ill            = (w_op > MEMOP_STRW_RI);
                w_dec.rd         = i_instr[c_rd_lsb +: 5];
                w_dec.rs         = i_instr[c_rs_lsb +: 5];
                w_dec.alu_config = binop_cfg(BINOP_ADD);
                if (w_op[0]) begin
                    w_dec.immedate = w_simm;
                end else begin
                    w_dec.rq = i_instr[c_rq_lsb +: 5];
                end
            end
            KIND_MODEL: begin
                w_dec.immedate = w_zimm;
            end
`ifdef DECODE_STAGE_CUSTOM_EN
            KIND_CUSTOM: begin
                w_dec.immedate = w_zimm;
            end
`endif
            default: begin
                w_ill = 1'b1;
            end
        endcase
        if (w_ill) begin
            w_dec      = '0;
            w_dec.kind = KIND_INVALID;
            w_dec.cond = COND_NV;
        end
    end

    assign o_decoded = w_dec;
    assign o_illegal = w_ill;

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
//------------------------------------------------------------------------------
// Module  : decode_stage
// Brief   : Decode pipeline stage with registered-ready skid buffer and a
//           saturating illegal-word counter. Option: DECODE_STAGE_CUSTOM_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module decode_stage
    import instruction::*;
#(
    parameter int ILL_CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$bits(s_decoded)-1:0]  out_decoded,
    output logic                         out_illegal,
    output logic [ILL_CNT_W-1:0]         ill_count
);

    e_stage_state         r_state;
    logic                 r_in_ready;
    s_decoded             r_out_dec;
    logic                 r_out_ill;
    s_decoded             r_skid_dec;
    logic                 r_skid_ill;
    logic [ILL_CNT_W-1:0] r_ill_count;

    s_decoded             w_dec;
    logic                 w_ill;
    logic                 w_accept;

    decode_comb u_decode_comb (
        .i_instr   (in_instr),
        .o_decoded (w_dec),
        .o_illegal (w_ill)
    );

    assign w_accept = in_valid && r_in_ready;

    // out_valid is implied by the state; ready toggles only on FULL entry/exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
            r_out_dec  <= '0;
            r_out_ill  <= 1'b0;
            r_skid_dec <= '0;
            r_skid_ill <= 1'b0;
        end else if (flush) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_out_dec <= w_dec;
                        r_out_ill <= w_ill;
                        r_state   <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !out_ready) begin
                        r_skid_dec <= w_dec;
                        r_skid_ill <= w_ill;
                        r_state    <= ST_FULL;
                        r_in_ready <= 1'b0;
                    end else if (w_accept) begin
                        r_out_dec <= w_dec;
                        r_out_ill <= w_ill;
                    end else if (out_ready) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        r_out_dec  <= r_skid_dec;
                        r_out_ill  <= r_skid_ill;
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ill_count <= '0;
        end else if (!flush && w_accept && w_ill && (r_ill_count != '1)) begin
            r_ill_count <= r_ill_count + ILL_CNT_W'(1);
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_state != ST_EMPTY);
    assign out_decoded = r_out_dec;
    assign out_illegal = r_out_ill;
    assign ill_count   = r_ill_count;

endmodule

`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter ILL_CNT_W, default 16, width of the saturating illegal-instruction counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  discards all held and incoming instructions this cycle.
REQ-005 in_valid  input  1  fetch word valid.
REQ-006 in_ready  output  1  stage can accept a word.
REQ-007 in_instr  input  32  raw instruction word.
REQ-008 out_valid  output  1  decoded record valid.
REQ-009 out_ready  input  1  downstream accepts the record.
REQ-010 out_decoded  output  $bits(instruction::s_decoded)  decoded record.
REQ-011 out_illegal  output  1  current out_decoded came from an illegal word.
REQ-012 ill_count  output  ILL_CNT_W  count of illegal words accepted; saturates.

Function
REQ-013 Field map: [31:29] kind, [28:26] cond, [25:21] op, [20:16] rd, [15:11] rs.
REQ-014 KIND_RRR: rq=[10:6], shift_type=[5:4], shift_amt={0,[3:0]}, immedate=0.
REQ-015 KIND_RRI: immedate = sign-extended [10:0], rq=0, shift fields 0.
REQ-016 KIND_MEMORY: *_RR ops set rq=[10:6] and immedate=0; *_RI ops set immedate = sign-extended [10:0] and rq=0.
REQ-017 KIND_MODEL: immedate = zero-extended [25:0]; rd, rs, rq and shift fields are 0.
REQ-018 Illegal word: kind 3'b101, 3'b110, or 3'b111; RRR/RRI op above BINOP_CMP; MEMORY op above MEMOP_STRW_RI.
REQ-019 Illegal word decodes to kind=KIND_INVALID and cond=COND_NV, with every other field 0 and out_illegal=1.
REQ-020 alu_config: the BINOP mapping for RRR/RRI; BINOP_ADD for MEMORY (address add); all-zero for other kinds.
REQ-021 Latency: exactly 1 cycle from an in_valid && in_ready edge to out_valid, when the output stage is empty.
REQ-022 Buffering: output register plus one skid entry; state machine EMPTY -> ONE -> FULL.
REQ-023 EMPTY->ONE on accept; ONE->FULL on accept without out_ready; FULL->ONE on out_ready; ONE->EMPTY on out_ready with no accept; ONE stays ONE on simultaneous accept and out_ready.
REQ-024 in_ready is registered and equals (state != FULL); it has no combinational path from out_ready.
REQ-025 Records leave in acceptance order; none is duplicated or dropped.
REQ-026 out_decoded and out_illegal stay stable while out_valid && !out_ready.
REQ-027 flush: state goes to EMPTY next cycle, the same-cycle input is dropped, and ill_count is unaffected by the dropped word.
REQ-028 flush has priority over accept and out_ready.
REQ-029 ill_count increments by 1 per accepted illegal word and holds at all-ones.

Reset
REQ-030 On rst: state=EMPTY, out_valid=0, in_ready=1 (from the cycle after rst deasserts), out_decoded=0, out_illegal=0, ill_count=0.
REQ-031 rst mid-transfer discards held records; no record is emitted for pre-reset words.

Configuration
REQ-032 Macro DECODE_STAGE_CUSTOM_EN controls KIND_CUSTOM decoding.
REQ-033 Defined: KIND_CUSTOM is legal, immedate = zero-extended [25:0], alu_config is 0.
REQ-034 Undefined: KIND_CUSTOM is decoded as illegal per REQ-019.

Structure
REQ-035 Field bit positions, the immediate width (11), and the state enum belong in package instruction.
REQ-036 Sub-module decode_comb holds the pure combinational word -> {s_decoded, illegal} logic; decode_stage holds handshake, skid and counter.

Verification
REQ-037 RRR word: kind=0, op=BINOP_SUB, rd=3, rs=4, rq=5, [5:4]=1, [3:0]=7 -> one cycle later out_valid=1, rd=3, rs=4, rq=5, shift_amt=7, immedate=0.
REQ-038 RRI word with [10:0]=11'h7FF -> immedate=32'hFFFFFFFF; with 11'h3FF -> 32'h000003FF.
REQ-039 Hold out_ready=0 while sending 3 words back-to-back -> in_ready drops after the 2nd word; release -> words emitted in order 1, 2, then 3 accepted.
REQ-040 Op 5'b11110 in an RRR word -> kind=KIND_INVALID, out_illegal=1, ill_count 0->1; with ILL_CNT_W=2, 5 illegal words -> ill_count=3.
REQ-041 Raise flush in FULL state together with a valid input -> next cycle out_valid=0 and in_ready=1; no stale record appears afterwards.
REQ-042 KIND_CUSTOM word -> legal with DECODE_STAGE_CUSTOM_EN defined, out_illegal=1 without it.
